sa_result_drain: RTL and testbench

Output-side drain for the systolic array pair. Captures each COL×32-bit partial-sum vector leaving the south edge when the last-row data-valid flag is high, buffers vectors in a small FIFO, and serializes them byte-by-byte over a valid/ready stream toward the UART transmitter. It is the return path complementing the UART-receive weight/data loader that feeds `in_north`/`in_west`.

---
 rtl/sa_result_drain.sv | 158 +++++++++++++++
 tb/tb_sa_result_drain.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sa_result_drain.sv
// sa_result_drain: south-edge result capture, vector FIFO and byte serializer.
// Each cycle in_dv is high, the COL x 32-bit vector on in_south is queued.
// Queued vectors are streamed out byte-by-byte over a valid/ready channel:
// column 0 first, each column little-endian.
// Optional build macro SA_DRAIN_HEADER_EN: prefix every vector with two
// header bytes, 0xA5 followed by an 8-bit running sequence number.
module sa_result_drain #(
  parameter int COL    = 32,
  parameter int W_RES  = 32,
  parameter int W_DATA = 8,
  parameter int DEPTH  = 4
) (
  input  logic                       in_clk,
  input  logic                       in_rst,
  input  logic [COL*W_RES-1:0]       in_south,
  input  logic                       in_dv,
  output logic [W_DATA-1:0]          out_byte,
  output logic                       out_byte_valid,
  input  logic                       in_byte_ready,
  output logic                       out_busy,
  output logic                       out_overflow,
  output logic [$clog2(DEPTH):0]     out_count
);

  localparam int VW  = COL * W_RES;      // bits per vector
  localparam int NB  = VW / W_DATA;      // bytes per vector
  localparam int AW  = $clog2(DEPTH);    // pointer width
  localparam int CW  = AW + 1;           // occupancy width
  localparam int BCW = $clog2(NB);       // byte counter width

  typedef enum logic [1:0] {IDLE, HDR0, HDR1, DATA} state_t;

  state_t              state;
  logic [VW-1:0]       mem [DEPTH];
  logic [AW-1:0]       wptr, rptr;
  logic [VW-1:0]       head;
  logic [VW-1:0]       sr;
  logic [BCW-1:0]      byte_cnt;
  logic [CW-1:0]       count_nxt;
  logic                full, push, pop, xfer, last, idle_nxt;
`ifdef SA_DRAIN_HEADER_EN
  logic [7:0]          seq;
`endif

  // A pop only happens when the serializer is idle, so a full FIFO can still
  // accept a vector in the exact cycle the head is handed to the serializer.
  assign full = (out_count == CW'(DEPTH));
  assign pop  = (state == IDLE) && (out_count != '0);
  assign push = in_dv && (!full || pop);
  assign xfer = out_byte_valid && in_byte_ready;
  assign last = (byte_cnt == BCW'(NB - 1));
  assign head = mem[rptr];

  // Next occupancy; push and pop together leave it unchanged.
  always_comb begin
    count_nxt = out_count;
    case ({push, pop})
      2'b10:   count_nxt = out_count + CW'(1);
      2'b01:   count_nxt = out_count - CW'(1);
      default: count_nxt = out_count;
    endcase
  end

  // Whether the serializer will sit in IDLE next cycle (feeds registered busy).
  always_comb begin
    idle_nxt = (state == IDLE) && !pop;
    if (state == DATA && xfer && last) idle_nxt = 1'b1;
  end

  // Vector storage; contents need no reset since pointers gate visibility.
  always_ff @(posedge in_clk) begin
    if (!in_rst && push) mem[wptr] <= in_south;
  end

  // FIFO pointers, occupancy and sticky overflow flag.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      wptr         <= '0;
      rptr         <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + AW'(1);
      if (pop)  rptr <= rptr + AW'(1);
      out_count <= count_nxt;
      if (in_dv && !push) out_overflow <= 1'b1;
    end
  end

  // Serializer FSM: loads the FIFO head and presents one byte at a time,
  // holding byte and valid steady until the downstream handshake.
  always_ff @(posedge in_clk) begin
    if (in_rst) begin
      state          <= IDLE;
      sr             <= '0;
      byte_cnt       <= '0;
      out_byte       <= '0;
      out_byte_valid <= 1'b0;
      out_busy       <= 1'b0;
`ifdef SA_DRAIN_HEADER_EN
      seq            <= '0;
`endif
    end else begin
      out_busy <= (count_nxt != '0) || !idle_nxt;
      case (state)
        IDLE: begin
          if (pop) begin
            byte_cnt       <= '0;
            out_byte_valid <= 1'b1;
`ifdef SA_DRAIN_HEADER_EN
            sr             <= head;
            out_byte       <= W_DATA'(8'hA5);
            state          <= HDR0;
`else
            sr             <= head >> W_DATA;
            out_byte       <= head[W_DATA-1:0];
            state          <= DATA;
`endif
          end
        end
`ifdef SA_DRAIN_HEADER_EN
        HDR0: begin
          if (xfer) begin
            out_byte <= W_DATA'(seq);
            seq      <= seq + 8'd1;
            state    <= HDR1;
          end
        end
        HDR1: begin
          if (xfer) begin
            out_byte <= sr[W_DATA-1:0];
            sr       <= sr >> W_DATA;
            byte_cnt <= '0;
            state    <= DATA;
          end
        end
`endif
        DATA: begin
          if (xfer) begin
            if (last) begin
              out_byte_valid <= 1'b0;
              state          <= IDLE;
            end else begin
              out_byte <= sr[W_DATA-1:0];
              sr       <= sr >> W_DATA;
              byte_cnt <= byte_cnt + BCW'(1);
            end
          end
        end
        default: begin
          out_byte_valid <= 1'b0;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sa_result_drain.sv
// Bench for sa_result_drain with COL=2, DEPTH=4. A table of single vectors
// is run with and without backpressure; hand sequences cover latency,
// overflow, full-with-pop, reset mid-stream and header sequencing.
module tb_sa_result_drain;

  localparam int COL = 2;
  localparam int DEPTH = 4;
`ifdef SA_DRAIN_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int NBV = COL * 4 + 2 * HDR;

  typedef logic [0:7][7:0] bytes_t;
  typedef struct {
    logic [31:0] c0;
    logic [31:0] c1;
    int          bp;
    bytes_t      exp;
  } vec_t;

  logic        in_clk = 1'b0;
  logic        in_rst = 1'b1;
  logic [63:0] in_south = '0;
  logic        in_dv = 1'b0;
  logic [7:0]  out_byte;
  logic        out_byte_valid;
  logic        in_byte_ready = 1'b1;
  logic        out_busy;
  logic        out_overflow;
  logic [2:0]  out_count;

  sa_result_drain #(.COL(COL), .W_RES(32), .W_DATA(8), .DEPTH(DEPTH)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .in_south(in_south), .in_dv(in_dv),
    .out_byte(out_byte), .out_byte_valid(out_byte_valid),
    .in_byte_ready(in_byte_ready), .out_busy(out_busy),
    .out_overflow(out_overflow), .out_count(out_count)
  );

  always #5 in_clk = ~in_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  int          stall_bad = 0;
  logic [7:0]  expq[$];
  logic [7:0]  rcvq[$];
  logic [7:0]  seq = 8'd0;
  int          rdy_mode = 0;   // 0: always ready, 1: 1,0,0 pattern, 2: manual
  logic        rdy_man = 1'b1;
  int          phase = 0;
  vec_t        tbl[4];

  // Ready driver, applied just after each rising edge.
  always @(posedge in_clk) begin
    #2;
    case (rdy_mode)
      0: in_byte_ready = 1'b1;
      1: begin in_byte_ready = (phase == 0); phase = (phase + 1) % 3; end
      default: in_byte_ready = rdy_man;
    endcase
  end

  // Byte collector and hold-while-stalled watcher.
  logic       stall_on = 1'b0;
  logic [7:0] stall_byte = '0;
  always @(negedge in_clk) begin
    if (in_rst) stall_on = 1'b0;
    else begin
      if (stall_on && (!out_byte_valid || out_byte != stall_byte)) stall_bad++;
      stall_on   = out_byte_valid && !in_byte_ready;
      stall_byte = out_byte;
      if (out_byte_valid && in_byte_ready) rcvq.push_back(out_byte);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic exp_bytes(input bytes_t b);
    if (HDR != 0) begin
      expq.push_back(8'hA5);
      expq.push_back(seq);
      seq = seq + 8'd1;
    end
    for (int k = 0; k < 8; k++) expq.push_back(b[k]);
  endtask

  task automatic exp_col(input logic [31:0] c0, input logic [31:0] c1);
    bytes_t      b;
    logic [63:0] v;
    v = {c1, c0};
    for (int k = 0; k < 8; k++) b[k] = v[8*k +: 8];
    exp_bytes(b);
  endtask

  // Called just after a rising edge; returns just after the next one.
  task automatic put(input logic [31:0] c0, input logic [31:0] c1);
    in_south = {c1, c0};
    in_dv = 1'b1;
    @(posedge in_clk); #1;
    in_dv = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge in_clk); #1;
    in_rst = 1'b1;
    in_dv = 1'b0;
    @(posedge in_clk); #1;
    in_rst = 1'b0;
    expq.delete();
    rcvq.delete();
    seq = 8'd0;
  endtask

  task automatic drain(input string nm);
    int t;
    t = 0;
    while ((rcvq.size() < expq.size() || out_busy) && t < 3000) begin
      @(negedge in_clk);
      t++;
    end
    chk({nm, "_done"}, 32'(t < 3000), 32'd1);
    chk({nm, "_len"}, rcvq.size(), expq.size());
    while (expq.size() > 0 && rcvq.size() > 0) chk(nm, rcvq.pop_front(), expq.pop_front());
    expq.delete();
    rcvq.delete();
    @(posedge in_clk); #1;
  endtask

  initial begin
    int t;
    tbl[0] = '{32'h11223344, 32'hAABBCCDD, 0, {8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA}};
    tbl[1] = '{32'h11223344, 32'hAABBCCDD, 1, {8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA}};
    tbl[2] = '{32'h00000000, 32'hFFFFFFFF, 0, {8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF}};
    tbl[3] = '{32'h01020304, 32'h80706050, 1, {8'h04, 8'h03, 8'h02, 8'h01, 8'h50, 8'h60, 8'h70, 8'h80}};

    // Reset values.
    repeat (2) @(posedge in_clk);
    #1;
    chk("rst_byte", 32'(out_byte), 0);
    chk("rst_valid", 32'(out_byte_valid), 0);
    chk("rst_busy", 32'(out_busy), 0);
    chk("rst_ovf", 32'(out_overflow), 0);
    chk("rst_count", 32'(out_count), 0);
    in_rst = 1'b0;
    @(posedge in_clk); #1;

    // Latency: in_dv in cycle N, first byte visible in N+2, then back-to-back.
    in_south = {tbl[0].c1, tbl[0].c0};
    in_dv = 1'b1;
    exp_bytes(tbl[0].exp);
    @(negedge in_clk);
    chk("lat_n_valid", 32'(out_byte_valid), 0);
    @(posedge in_clk); #1;
    in_dv = 1'b0;
    @(negedge in_clk);
    chk("lat_n1_valid", 32'(out_byte_valid), 0);
    chk("lat_n1_count", 32'(out_count), 1);
    chk("lat_n1_busy", 32'(out_busy), 1);
    @(negedge in_clk);
    chk("lat_n2_valid", 32'(out_byte_valid), 1);
    chk("lat_n2_byte", 32'(out_byte), (HDR != 0) ? 32'hA5 : 32'h44);
    chk("lat_n2_count", 32'(out_count), 0);
    for (int k = 1; k < NBV; k++) begin
      @(negedge in_clk);
      chk($sformatf("lat_stream%0d", k), 32'(out_byte_valid), 1);
    end
    @(negedge in_clk);
    chk("lat_after_valid", 32'(out_byte_valid), 0);
    drain("lat");
    chk("lat_idle_busy", 32'(out_busy), 0);

    // Table: single vectors, with and without backpressure.
    for (int i = 0; i < 4; i++) begin
      rdy_mode = tbl[i].bp;
      @(posedge in_clk); #1;
      exp_bytes(tbl[i].exp);
      put(tbl[i].c0, tbl[i].c1);
      drain($sformatf("tbl%0d", i));
    end
    chk("stall_hold", 32'(stall_bad), 0);

    // Overflow: serializer stalled on one vector, six more arrive back to back.
    do_reset();
    rdy_mode = 2;
    rdy_man = 1'b0;
    exp_col(32'hF0, 32'h0);
    put(32'hF0, 32'h0);
    @(posedge in_clk); #1;
    for (int v = 1; v <= 6; v++) begin
      if (v <= 4) exp_col(32'(v), 32'h0);
      put(32'(v), 32'h0);
    end
    chk("ovf_count", 32'(out_count), 4);
    chk("ovf_flag", 32'(out_overflow), 1);
    rdy_man = 1'b1;
    drain("ovf");
    chk("ovf_sticky", 32'(out_overflow), 1);
    chk("ovf_empty", 32'(out_count), 0);

    // Full FIFO, serializer finishing: in_dv in the pop cycle is accepted.
    do_reset();
    rdy_mode = 2;
    rdy_man = 1'b0;
    exp_col(32'hA0, 32'hA1);
    put(32'hA0, 32'hA1);
    @(posedge in_clk); #1;
    for (int v = 0; v < 4; v++) begin
      exp_col(32'hB0 + 32'(v), 32'hC0 + 32'(v));
      put(32'hB0 + 32'(v), 32'hC0 + 32'(v));
    end
    chk("fp_full", 32'(out_count), 4);
    rdy_man = 1'b1;
    t = 0;
    @(negedge in_clk);
    while (out_byte_valid && t < 200) begin
      @(negedge in_clk);
      t++;
    end
    chk("fp_found_idle", 32'(t < 200), 1);
    in_south = {32'hEEEE0001, 32'hDDDD0002};
    in_dv = 1'b1;
    exp_col(32'hDDDD0002, 32'hEEEE0001);
    @(posedge in_clk); #1;
    in_dv = 1'b0;
    chk("fp_count", 32'(out_count), 4);
    chk("fp_ovf", 32'(out_overflow), 0);
    drain("fp");

    // Reset after four bytes of a vector have gone out.
    do_reset();
    rdy_mode = 0;
    put(32'h55667788, 32'h99AABBCC);
    t = 0;
    while (rcvq.size() < 4 + 2 * HDR && t < 100) begin
      @(negedge in_clk);
      t++;
    end
    chk("mr_reached", 32'(t < 100), 1);
    @(posedge in_clk); #1;
    in_rst = 1'b1;
    @(posedge in_clk); #1;
    chk("mr_byte", 32'(out_byte), 0);
    chk("mr_valid", 32'(out_byte_valid), 0);
    chk("mr_busy", 32'(out_busy), 0);
    chk("mr_count", 32'(out_count), 0);
    in_rst = 1'b0;
    expq.delete();
    rcvq.delete();
    seq = 8'd0;
    repeat (5) @(posedge in_clk);
    #1;
    chk("mr_quiet", 32'(rcvq.size()), 0);
    exp_col(32'h0BADF00D, 32'hCAFEBABE);
    put(32'h0BADF00D, 32'hCAFEBABE);
    drain("mr_restart");

    // Three vectors after reset: header sequence numbers start at zero.
    do_reset();
    rdy_mode = 0;
    for (int v = 0; v < 3; v++) begin
      exp_col(32'h100 + 32'(v), 32'h200 + 32'(v));
      put(32'h100 + 32'(v), 32'h200 + 32'(v));
    end
    drain("seq3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
